// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Desc   : Shared widths, state encoding and latency limit for the
//          memory-stage access unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_TAG_W  = 3;
    localparam int MAX_READ_LAT   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module : mem_access_unit
// Desc   : Memory-stage initiator: accepts load/store requests, drives the
//          data-memory port and returns load data with its register tag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int TAG_W    = DEFAULT_TAG_W,
    parameter int READ_LAT = 0
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_rd,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] ALUResult,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_rd,
    output logic              busy
);

    localparam int             CNT_W = $clog2(MAX_READ_LAT + 1);
    localparam logic [CNT_W-1:0] c_lat = CNT_W'(READ_LAT);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [TAG_W-1:0]   r_rd;
    logic               w_accept;

    assign req_ready = (r_state == IDLE) && reset_n;
    assign busy      = (r_state != IDLE);
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rd       <= '0;
            MemWrite   <= 1'b0;
            ALUResult  <= '0;
            WriteData  <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        ALUResult <= req_addr;
                        r_rd      <= req_rd;
                        if (req_write) begin
                            // WriteData only moves on stores so it never changes outside WR
                            WriteData <= req_wdata;
                            MemWrite  <= 1'b1;
                            r_state   <= WR;
                        end else begin
                            r_cnt   <= c_lat;
                            r_state <= RD;
                        end
                    end
                end
                WR: begin
                    MemWrite <= 1'b0;
                    r_state  <= IDLE;
                end
                RD: begin
                    if (r_cnt == '0) begin
                        resp_data  <= ReadData;
                        resp_rd    <= r_rd;
                        resp_valid <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : mem_access_unit

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module : tb_mem_access_unit
// Desc   : Self-checking bench; four units (READ_LAT 0..3) each with a data
//          memory responder, scoreboard-checked load stream on lane 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam int NL = 4;

    typedef struct packed {
        logic [2:0] rd;
        logic [7:0] data;
    } exp_t;

    logic            clk;
    logic            r_reset_n;
    logic [NL-1:0]   r_req_valid;
    logic [NL-1:0]   r_resp_ready;
    logic            r_req_write;
    logic [7:0]      r_req_addr;
    logic [7:0]      r_req_wdata;
    logic [2:0]      r_req_rd;

    logic [NL-1:0]   w_req_ready;
    logic [NL-1:0]   w_mem_write;
    logic [NL-1:0]   w_resp_valid;
    logic [NL-1:0]   w_busy;
    logic [7:0]      w_alu      [NL];
    logic [7:0]      w_wdata    [NL];
    logic [7:0]      w_rdata    [NL];
    logic [7:0]      w_resp_data[NL];
    logic [2:0]      w_resp_rd  [NL];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   mw_cnt   = 0;
    exp_t exp_q[$];
    logic [7:0] sb_mem [256];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (w_mem_write[0] === 1'b1) mw_cnt <= mw_cnt + 1;

    for (genvar l = 0; l < NL; l++) begin : g_lane
        logic [7:0] mem  [256];
        logic [7:0] pipe [3];

        mem_access_unit #(.READ_LAT(l)) u_dut (
            .CLK        (clk),
            .reset_n    (r_reset_n),
            .req_valid  (r_req_valid[l]),
            .req_ready  (w_req_ready[l]),
            .req_write  (r_req_write),
            .req_addr   (r_req_addr),
            .req_wdata  (r_req_wdata),
            .req_rd     (r_req_rd),
            .MemWrite   (w_mem_write[l]),
            .ALUResult  (w_alu[l]),
            .WriteData  (w_wdata[l]),
            .ReadData   (w_rdata[l]),
            .resp_valid (w_resp_valid[l]),
            .resp_ready (r_resp_ready[l]),
            .resp_data  (w_resp_data[l]),
            .resp_rd    (w_resp_rd[l]),
            .busy       (w_busy[l])
        );

        always @(posedge clk) if (w_mem_write[l]) mem[w_alu[l]] <= w_wdata[l];

        // Read data appears l clock edges after the address is presented
        if (l == 0) begin : g_comb
            assign w_rdata[l] = mem[w_alu[l]];
        end else begin : g_pipe
            always @(posedge clk) begin
                pipe[0] <= mem[w_alu[l]];
                for (int k = 1; k < 3; k++) pipe[k] <= pipe[k-1];
            end
            assign w_rdata[l] = pipe[l-1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request on lane l once it is ready; acc = cycle of the accept edge
    task automatic drive_req(input int l, input logic w, input logic [7:0] a,
                             input logic [7:0] d, input logic [2:0] rd, output int acc);
        int n = 0;
        while (!w_req_ready[l] && n < 20) begin
            tick();
            n++;
        end
        if (!w_req_ready[l]) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout lane %0d: req_ready=%b required 1", l, w_req_ready[l]);
        end
        r_req_write    = w;
        r_req_addr     = a;
        r_req_wdata    = d;
        r_req_rd       = rd;
        r_req_valid[l] = 1'b1;
        acc = cyc;
        tick();
        r_req_valid[l] = 1'b0;
    endtask

    task automatic test_reset();
        r_reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (w_mem_write[0] !== 1'b0 || w_resp_valid[0] !== 1'b0 || w_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: memwrite=%b resp_valid=%b busy=%b required 0 0 0",
                     w_mem_write[0], w_resp_valid[0], w_busy[0]);
        end
        checks++;
        if (w_alu[0] !== 8'h00 || w_wdata[0] !== 8'h00 || w_resp_data[0] !== 8'h00 || w_resp_rd[0] !== 3'd0) begin
            failures++;
            $display("FAIL reset_data: alu=%h wdata=%h resp_data=%h resp_rd=%0d required all 0",
                     w_alu[0], w_wdata[0], w_resp_data[0], w_resp_rd[0]);
        end
        r_reset_n = 1'b1;
        #1;
        checks++;
        if (w_req_ready !== 4'hF) begin
            failures++;
            $display("FAIL reset_req_ready: got %b required 1111", w_req_ready);
        end
    endtask

    task automatic test_store();
        int n;
        drive_req(0, 1'b1, 8'h10, 8'hA5, 3'd0, n);
        checks++;
        if (w_mem_write[0] !== 1'b1 || w_alu[0] !== 8'h10 || w_wdata[0] !== 8'hA5 || w_req_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL store_wr: memwrite=%b alu=%h wdata=%h req_ready=%b required 1 10 a5 0",
                     w_mem_write[0], w_alu[0], w_wdata[0], w_req_ready[0]);
        end
        tick();
        checks++;
        if (w_mem_write[0] !== 1'b0 || w_req_ready[0] !== 1'b1 || w_alu[0] !== 8'h10 || w_wdata[0] !== 8'hA5) begin
            failures++;
            $display("FAIL store_done: memwrite=%b req_ready=%b alu=%h wdata=%h required 0 1 10 a5",
                     w_mem_write[0], w_req_ready[0], w_alu[0], w_wdata[0]);
        end
        checks++;
        if (g_lane[0].mem[8'h10] !== 8'hA5) begin
            failures++;
            $display("FAIL store_mem: mem[10]=%h required a5", g_lane[0].mem[8'h10]);
        end
    endtask

    task automatic test_store_load();
        int   n;
        int   w;
        exp_t e;
        r_resp_ready[0] = 1'b1;
        drive_req(0, 1'b1, 8'h80, 8'h3C, 3'd0, n);
        drive_req(0, 1'b0, 8'h80, 8'h00, 3'd5, n);
        e.rd = 3'd5;
        e.data = 8'h3C;
        exp_q.push_back(e);
        w = 0;
        while (!w_resp_valid[0] && w < 20) begin
            tick();
            w++;
        end
        checks++;
        if (cyc - n != 2) begin
            failures++;
            $display("FAIL raw_latency: got %0d cycles required 2", cyc - n);
        end
        if (w_resp_valid[0] && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (w_resp_data[0] !== e.data || w_resp_rd[0] !== e.rd) begin
                failures++;
                $display("FAIL raw_data: data=%h rd=%0d required %h %0d",
                         w_resp_data[0], w_resp_rd[0], e.data, e.rd);
            end
        end
        tick();
        checks++;
        if (w_resp_valid[0] !== 1'b0 || w_req_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL raw_release: resp_valid=%b req_ready=%b required 0 1",
                     w_resp_valid[0], w_req_ready[0]);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int n;
        int w;
        r_resp_ready[0] = 1'b0;
        drive_req(0, 1'b0, 8'h10, 8'h00, 3'd2, n);
        // A competing store is held valid throughout and must never be taken
        r_req_valid[0] = 1'b1;
        r_req_write    = 1'b1;
        r_req_addr     = 8'h33;
        r_req_wdata    = 8'hEE;
        w = 0;
        while (!w_resp_valid[0] && w < 20) begin
            tick();
            w++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_resp_valid[0] !== 1'b1 || w_resp_data[0] !== 8'hA5 || w_resp_rd[0] !== 3'd2 || w_req_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: resp_valid=%b data=%h rd=%0d req_ready=%b required 1 a5 2 0",
                         i, w_resp_valid[0], w_resp_data[0], w_resp_rd[0], w_req_ready[0]);
            end
            tick();
        end
        r_req_valid[0]  = 1'b0;
        r_resp_ready[0] = 1'b1;
        tick();
        checks++;
        if (w_resp_valid[0] !== 1'b0 || w_mem_write[0] !== 1'b0 || w_alu[0] !== 8'h10) begin
            failures++;
            $display("FAIL bp_release: resp_valid=%b memwrite=%b alu=%h required 0 0 10",
                     w_resp_valid[0], w_mem_write[0], w_alu[0]);
        end
    endtask

    task automatic test_latency_sweep();
        int n;
        int w;
        for (int l = 0; l < NL; l++) begin
            r_resp_ready[l] = 1'b1;
            drive_req(l, 1'b1, 8'hFF, 8'h5A, 3'd0, n);
            // Fill the read path with different data so an early capture shows
            drive_req(l, 1'b1, 8'h00, 8'h11, 3'd0, n);
            drive_req(l, 1'b0, 8'hFF, 8'h00, 3'd7, n);
            w = 0;
            while (!w_resp_valid[l] && w < 20) begin
                tick();
                w++;
            end
            checks++;
            if (cyc - n != 2 + l) begin
                failures++;
                $display("FAIL lat_sweep[%0d]: got %0d cycles required %0d", l, cyc - n, 2 + l);
            end
            checks++;
            if (w_resp_data[l] !== 8'h5A || w_resp_rd[l] !== 3'd7) begin
                failures++;
                $display("FAIL lat_data[%0d]: data=%h rd=%0d required 5a 7", l, w_resp_data[l], w_resp_rd[l]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int w;
        int seen = 0;
        r_resp_ready[3] = 1'b0;
        drive_req(3, 1'b0, 8'hFF, 8'h00, 3'd1, n);
        #2 r_reset_n = 1'b0;
        #1;
        checks++;
        if (w_busy[3] !== 1'b0 || w_resp_valid[3] !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_rd: busy=%b resp_valid=%b required 0 0", w_busy[3], w_resp_valid[3]);
        end
        tick();
        r_reset_n = 1'b1;

        drive_req(0, 1'b1, 8'h22, 8'h99, 3'd0, n);
        #2 r_reset_n = 1'b0;
        #1;
        checks++;
        if (w_mem_write[0] !== 1'b0 || w_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_wr: memwrite=%b busy=%b required 0 0", w_mem_write[0], w_busy[0]);
        end
        tick();
        checks++;
        if (g_lane[0].mem[8'h22] === 8'h99) begin
            failures++;
            $display("FAIL rst_wr_commit: mem[22]=%h required not 99", g_lane[0].mem[8'h22]);
        end
        r_reset_n = 1'b1;

        r_resp_ready[0] = 1'b0;
        drive_req(0, 1'b0, 8'h10, 8'h00, 3'd4, n);
        w = 0;
        while (!w_resp_valid[0] && w < 20) begin
            tick();
            w++;
        end
        #2 r_reset_n = 1'b0;
        #1;
        checks++;
        if (w_resp_valid[0] !== 1'b0 || w_busy[0] !== 1'b0 || w_resp_data[0] !== 8'h00) begin
            failures++;
            $display("FAIL rst_in_resp: resp_valid=%b busy=%b data=%h required 0 0 00",
                     w_resp_valid[0], w_busy[0], w_resp_data[0]);
        end
        tick();
        r_reset_n    = 1'b1;
        r_resp_ready = 4'hF;
        for (int i = 0; i < 10; i++) begin
            if (w_resp_valid !== 4'h0 || w_busy !== 4'h0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_no_replay: %0d cycles with activity required 0", seen);
        end
    endtask

    task automatic test_random_stream();
        int   n;
        int   cycles = 0;
        int   issued = 0;
        int   stores = 0;
        int   mw0;
        exp_t e;
        logic [7:0] a;
        mw0 = mw_cnt;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            a = 8'h40 + 8'(i);
            sb_mem[a] = 8'($urandom_range(0, 255));
            drive_req(0, 1'b1, a, sb_mem[a], 3'd0, n);
            stores++;
        end
        issued = 8;
        while ((issued < 200 || exp_q.size() != 0 || w_busy[0]) && cycles < 5000) begin
            r_resp_ready[0] = ($urandom_range(0, 3) != 0);
            r_req_valid[0]  = (issued < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            r_req_write     = 1'($urandom_range(0, 1));
            r_req_addr      = 8'h40 + 8'($urandom_range(0, 7));
            r_req_wdata     = 8'($urandom_range(0, 255));
            r_req_rd        = 3'($urandom_range(0, 7));
            if (w_resp_valid[0] && r_resp_ready[0]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_spurious: data=%h rd=%0d with no load outstanding",
                             w_resp_data[0], w_resp_rd[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (w_resp_data[0] !== e.data || w_resp_rd[0] !== e.rd) begin
                        failures++;
                        $display("FAIL rand_load: data=%h rd=%0d required %h %0d",
                                 w_resp_data[0], w_resp_rd[0], e.data, e.rd);
                    end
                end
            end
            if (r_req_valid[0] && w_req_ready[0]) begin
                issued++;
                if (r_req_write) begin
                    sb_mem[r_req_addr] = r_req_wdata;
                    stores++;
                end else begin
                    e.rd   = r_req_rd;
                    e.data = sb_mem[r_req_addr];
                    exp_q.push_back(e);
                end
            end
            tick();
            cycles++;
        end
        r_req_valid[0] = 1'b0;
        checks++;
        if (exp_q.size() != 0 || issued != 200) begin
            failures++;
            $display("FAIL rand_lost: %0d responses outstanding, %0d issued, required 0 and 200",
                     exp_q.size(), issued);
        end
        checks++;
        if (mw_cnt - mw0 != stores) begin
            failures++;
            $display("FAIL rand_memwrite: %0d pulses required %0d", mw_cnt - mw0, stores);
        end
    endtask

    initial begin
        r_reset_n    = 1'b0;
        r_req_valid  = '0;
        r_resp_ready = '0;
        r_req_write  = 1'b0;
        r_req_addr   = '0;
        r_req_wdata  = '0;
        r_req_rd     = '0;
        test_reset();
        test_store();
        test_store_load();
        test_backpressure();
        test_latency_sweep();
        test_reset_mid();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_access_unit

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage initiator for the 8-bit pipelined core. It takes load/store requests from the execute stage over a valid/ready handshake and drives the data-memory write-enable, address and write-data ports. For loads it samples the memory read data after a programmable latency and returns it with its destination-register tag to writeback over a second valid/ready handshake. It is the requesting end of the data-memory interface.

Parameters:
ADDR_W, 8, address width; must match the data-memory depth of 256.
DATA_W, 8, data width.
TAG_W, 3, width of the destination-register tag for 8 GPRs.
READ_LAT, 0, number of extra cycles between address presentation and ReadData being valid; legal range 0..3.

Ports:
CLK  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  execute stage presents a request.
req_ready  out  1  unit accepts a request this cycle.
req_write  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  effective address (ALU result).
req_wdata  in  DATA_W  store data.
req_rd  in  TAG_W  load destination register tag.
MemWrite  out  1  data-memory write enable.
ALUResult  out  ADDR_W  data-memory address.
WriteData  out  DATA_W  data-memory write data.
ReadData  in  DATA_W  data-memory read data.
resp_valid  out  1  load result available.
resp_ready  in  1  writeback accepts the result.
resp_data  out  DATA_W  loaded value.
resp_rd  out  TAG_W  destination tag of the loaded value.
busy  out  1  state is not IDLE; drives the pipeline stall.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE. MemWrite, ALUResult, WriteData, resp_valid, resp_data, resp_rd, the latency counter and busy all go to 0. req_ready=1 once reset_n is high.
- Any in-flight request or pending response is discarded on reset; nothing is replayed.
- FSM states: IDLE, WR, RD, RESP.
- req_ready=1 only in IDLE. A request is accepted on a cycle with req_valid & req_ready. On acceptance, addr/wdata/rd/write are latched.
- IDLE -> WR on an accepted store. WR lasts exactly one cycle: MemWrite=1, ALUResult=addr, WriteData=wdata. The memory commits on the edge that ends WR. WR -> IDLE. Stores produce no response.
- IDLE -> RD on an accepted load. ALUResult=addr and MemWrite=0. The counter loads READ_LAT and decrements each RD cycle. When the counter is 0, ReadData is captured into resp_data and the state goes RD -> RESP.
- Load latency: accept at cycle N gives resp_valid high at cycle N+2+READ_LAT.
- RESP: resp_valid=1. resp_data and resp_rd are held stable until resp_ready. Leaving RESP requires resp_valid & resp_ready; the state then goes to IDLE with resp_valid=0 next cycle.
- Back-to-back requests: no overlap. The next request can be accepted no earlier than the cycle after the unit returns to IDLE.
- Store throughput is 1 per 2 cycles. Load throughput is 1 per 3+READ_LAT cycles with resp_ready tied high.
- Outside WR, MemWrite=0. ALUResult and WriteData hold their last values, with no glitching back to 0.
- Read-after-write to the same address returns the new data, because the store commits before the load's RD cycle.
- Address wrap: 8-bit, no bounds check; 0xFF is a legal address.
- A req_valid that drops while req_ready=0 is legal and ignored. Request fields are sampled only on the accept cycle.
- busy = (state != IDLE).

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_W, DATA_W, TAG_W defaults;
  - the state encoding (IDLE=2'd0, WR=2'd1, RD=2'd2, RESP=2'd3);
  - a MAX_READ_LAT=3 constant.
- The design is a single module with no sub-module; a 2-bit down-counter inline is sufficient.
- The bench instantiates the existing data memory as the responder.

Test Plan:
1. Reset then store: reset_n low 2 cycles, then store addr 0x10 data 0xA5 -> MemWrite=1 for exactly 1 cycle with ALUResult=0x10, WriteData=0xA5; memory[0x10]=0xA5; req_ready back to 1 two cycles after accept.
2. Store-then-load: store 0x3C to 0x80, then load 0x80 with rd=5 and READ_LAT=0 -> resp_valid 2 cycles after load accept, resp_data=0x3C, resp_rd=5.
3. Backpressure: load from 0x10 with resp_ready=0 for 4 cycles -> resp_valid held high, resp_data=0xA5 stable, req_ready=0 throughout; resp_ready=1 -> resp_valid drops the next cycle.
4. Latency sweep: READ_LAT=3, load from 0xFF preloaded with 0x5A -> resp_valid exactly 5 cycles after accept, data=0x5A; the latency is checked for READ_LAT values 0 through 3.
5. Reset mid-operation: assert reset_n low during RD -> resp_valid, MemWrite and busy are 0 immediately (asynchronously), and no response appears after release.
6. Random stream: 200 random load/store requests with random req_valid/resp_ready -> every load matches a scoreboard, MemWrite pulses equal the store count, and no response is ever lost or duplicated.
